// File: rtl/imm_alu_unit.sv
// imm_alu_unit: RV32 immediate generator and ALU with one-cycle registered outputs.
// Immediate and ALU result are computed combinationally and captured only on in_valid.
module imm_alu_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_type,
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    input  logic            use_imm,
    input  logic [3:0]      fn,
    output logic            out_valid,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] alu_out
);
    logic [XLEN-1:0] imm, op1, alu;
    logic [XLEN-1:0] imm_d, imm_q, alu_d, alu_q;
    logic            valid_d, valid_q;
    logic [4:0]      shamt;

    always_comb begin
        imm = imm_type == 3'd0 ? {{20{inst[31]}}, inst[31:20]} :
              imm_type == 3'd1 ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
              imm_type == 3'd2 ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
              imm_type == 3'd3 ? {inst[31:12], 12'b0} :
              imm_type == 3'd4 ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
              '0;
        op1 = use_imm ? imm : src1;
        shamt = op1[4:0];
        alu = '0;
        case (fn)
            4'd0:  alu = src0 + op1;
            4'd1:  alu = src0 - op1;
            4'd2:  alu = src0 << shamt;
            4'd3:  alu = {{(XLEN-1){1'b0}}, $signed(src0) < $signed(op1)};
            4'd4:  alu = {{(XLEN-1){1'b0}}, src0 < op1};
            4'd5:  alu = src0 ^ op1;
            4'd6:  alu = src0 >> shamt;
            4'd7:  alu = $signed(src0) >>> shamt;
            4'd8:  alu = src0 | op1;
            4'd9:  alu = src0 & op1;
            4'd10: alu = op1;
            default: alu = '0;
        endcase
        valid_d = in_valid;
        imm_d   = in_valid ? imm : imm_q;
        alu_d   = in_valid ? alu : alu_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
            alu_q   <= '0;
        end else begin
            valid_q <= valid_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
        end
    end

    assign out_valid = valid_q;
    assign imm_out   = imm_q;
    assign alu_out   = alu_q;
endmodule

// File: tb/tb_imm_alu_unit.sv
// tb_imm_alu_unit: scoreboard bench for imm_alu_unit with directed and random operations.
module tb_imm_alu_unit;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic [31:0] inst = 0;
    logic [2:0]  imm_type = 0;
    logic [31:0] src0 = 0;
    logic [31:0] src1 = 0;
    logic        use_imm = 0;
    logic [3:0]  fn = 0;
    logic        out_valid;
    logic [31:0] imm_out;
    logic [31:0] alu_out;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] alu;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    imm_alu_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .imm_type(imm_type),
        .src0(src0), .src1(src1), .use_imm(use_imm), .fn(fn),
        .out_valid(out_valid), .imm_out(imm_out), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input longint v, input int bits);
        longint r;
        r = v >= (longint'(1) << (bits - 1)) ? v - (longint'(1) << bits) : v;
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
        case (t)
            3'd0: return sext(longint'(i[31:20]), 12);
            3'd1: return sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            3'd2: return sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                              + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            3'd3: return sext(longint'(i[31:12]) * 4096, 32);
            3'd4: return sext(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                              + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] f);
        longint a, b, sa, sb, p, r;
        a  = longint'(x);
        b  = longint'(y);
        sa = a >= 64'h8000_0000 ? a - 64'h1_0000_0000 : a;
        sb = b >= 64'h8000_0000 ? b - 64'h1_0000_0000 : b;
        p  = longint'(1) << (b % 32);
        case (f)
            4'd0:  r = a + b;
            4'd1:  r = a - b + 64'h1_0000_0000;
            4'd2:  r = a * p;
            4'd3:  r = sa < sb ? 1 : 0;
            4'd4:  r = a < b ? 1 : 0;
            4'd5:  r = a ^ b;
            4'd6:  r = a / p;
            4'd7:  r = sa >= 0 ? sa / p : (sa - (p - 1)) / p;
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: r = b;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input logic [31:0] i, input logic [2:0] t, input logic [31:0] s0,
                         input logic [31:0] s1, input logic u, input logic [3:0] f,
                         input logic [31:0] ei, input logic [31:0] ea);
        exp_t e;
        @(negedge clk);
        in_valid = 1; inst = i; imm_type = t; src0 = s0; src1 = s1; use_imm = u; fn = f;
        e.imm = ei;
        e.alu = ea;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 0;
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("imm_out", imm_out, e.imm);
                chk("alu_out", alu_out, e.alu);
            end
        end
    end

    initial begin
        logic [31:0] ri, rs0, rs1, rimm, rop1;
        logic [2:0]  rt;
        logic [3:0]  rf;
        logic        ru;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_imm_out", imm_out, 32'd0);
        chk("reset_alu_out", alu_out, 32'd0);
        @(negedge clk);
        rst = 1;
        drive(32'h00100093, 3'd0, 0, 0, 1, 4'd0, 32'h1, 32'h1);
        drive(32'hFFF00093, 3'd0, 0, 0, 1, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(32'hFE000FA3, 3'd1, 0, 0, 1, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(32'h00000463, 3'd2, 0, 0, 1, 4'd10, 32'h8, 32'h8);
        drive(32'h12345037, 3'd3, 0, 0, 1, 4'd10, 32'h12345000, 32'h12345000);
        drive(32'h0040006F, 3'd4, 0, 0, 1, 4'd10, 32'h4, 32'h4);
        drive(32'h0040006F, 3'd7, 0, 0, 1, 4'd10, 32'h0, 32'h0);
        drive(32'h0, 3'd0, 5, 7, 0, 4'd1, 32'h0, 32'hFFFFFFFE);
        drive(32'h0, 3'd0, 32'h80000000, 4, 0, 4'd7, 32'h0, 32'hF8000000);
        drive(32'h0, 3'd0, 32'h80000000, 4, 0, 4'd6, 32'h0, 32'h08000000);
        drive(32'h0, 3'd0, 1, 32'h24, 0, 4'd2, 32'h0, 32'h10);
        drive(32'h0, 3'd0, 32'hFFFFFFFF, 1, 0, 4'd3, 32'h0, 32'h1);
        drive(32'h0, 3'd0, 32'hFFFFFFFF, 1, 0, 4'd4, 32'h0, 32'h0);
        drive(32'h0, 3'd0, 32'h12345678, 1, 0, 4'd15, 32'h0, 32'h0);
        drive(32'h0, 3'd0, 1, 1, 0, 4'd0, 32'h0, 32'h2);
        drive(32'h0, 3'd0, 2, 2, 0, 4'd0, 32'h0, 32'h4);
        drive(32'h0, 3'd0, 3, 3, 0, 4'd0, 32'h0, 32'h6);
        drive(32'h00100093, 3'd0, 0, 0, 1, 4'd0, 32'h1, 32'h1);
        idle();
        @(negedge clk);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_alu_out", alu_out, 32'h1);
        chk("hold_imm_out", imm_out, 32'h1);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_imm_out", imm_out, 32'd0);
        chk("async_reset_alu_out", alu_out, 32'd0);
        @(negedge clk);
        in_valid = 1; src0 = 9; src1 = 9; fn = 4'd0; use_imm = 0;
        @(negedge clk);
        chk("in_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("in_reset_alu_out", alu_out, 32'd0);
        in_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("post_release_out_valid", {31'd0, out_valid}, 32'd0);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) begin
                idle();
            end else begin
                ri   = $urandom;
                rt   = 3'($urandom_range(7));
                rf   = 4'($urandom_range(15));
                ru   = 1'($urandom_range(1));
                rs0  = $urandom;
                rs1  = $urandom_range(1) ? $urandom : $urandom_range(40);
                rimm = ref_imm(ri, rt);
                rop1 = ru ? rimm : rs1;
                drive(ri, rt, rs0, rs1, ru, rf, rimm, ref_alu(rs0, rop1, rf));
            end
        end
        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_alu_unit.md
# imm_alu_unit

Execute-stage datapath block for the single-cycle RV32 core. It has two parts:
- an immediate generator that extracts and sign-extends the immediate of a 32-bit instruction in I/S/B/U/J format;
- a 32-bit ALU that combines the rs1 operand with either rs2 or the generated immediate.

Results are registered: the block presents one-cycle-latency outputs to the write-back logic.

## Interface
Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock. All registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-low. This is fixed. Asserting it (low) clears all output registers immediately.
- in_valid  in  1  the operands and instruction this cycle are to be executed.
- inst  in  32  raw instruction word.
- imm_type  in  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J. 101–111 are reserved.
- src0  in  32  rs1 value; ALU operand 0.
- src1  in  32  rs2 value.
- use_imm  in  1  1 selects the generated immediate as ALU operand 1; 0 selects src1.
- fn  in  4  ALU function code.
- out_valid  out  1  registered in_valid.
- imm_out  out  32  registered immediate.
- alu_out  out  32  registered ALU result.

## Operation
Immediate generation is combinational and uses inst only.
- I: sign-extend inst[31:20].
- S: sign-extend {inst[31:25], inst[11:7]}.
- B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- U: {inst[31:12], 12'b0}.
- J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- Reserved imm_type values produce 0.

ALU operands:
- op0 = src0.
- op1 = use_imm ? immediate : src1.
- All arithmetic is modulo 2^32. There is no overflow or carry output.

ALU function codes (fn):
- 0000 ADD: op0+op1.
- 0001 SUB: op0−op1.
- 0010 SLL: op0 << op1[4:0].
- 0011 SLT: signed op0<op1 gives 1, else 0.
- 0100 SLTU: unsigned compare, same result encoding.
- 0101 XOR.
- 0110 SRL: logical shift right by op1[4:0].
- 0111 SRA: arithmetic shift right by op1[4:0].
- 1000 OR.
- 1001 AND.
- 1010 PASS: op1 (used for LUI).
- 1011–1111: result 0.
- Shift amounts ignore op1[31:5].

Register behaviour:
- Every rising edge with rst high: out_valid ← in_valid.
- When in_valid=1: imm_out and alu_out load the new values.
- When in_valid=0: imm_out and alu_out hold their previous values.
- No internal state other than these output registers. No handshake and no backpressure.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per cycle. Back-to-back in_valid is fully supported.
- Reset values: out_valid=0, imm_out=0x00000000, alu_out=0x00000000.
- Reset is asynchronous: the outputs clear without waiting for a clock edge.
- Reset is released synchronously to clk. The first capture is at the first rising edge with rst high.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid reads 0 until in_valid is captured after release.
- The combinational path inst/imm_type/src*/fn → register D input must close timing in one cycle. There are no combinational input-to-output paths.

## Test plan
- Reset and ADDI:
  - Hold rst=0: all outputs 0.
  - Release rst, then apply inst=0x00100093, imm_type=000, src0=0, use_imm=1, fn=0000, in_valid=1.
  - Next cycle: imm_out=0x00000001, alu_out=0x00000001, out_valid=1.
- Immediate formats, use_imm=1, src0=0, fn=1010:
  - inst 0xFFF00093 with I → 0xFFFFFFFF.
  - inst 0xFE000FA3 with S → 0xFFFFFFFF.
  - inst 0x00000463 with B → 0x00000008.
  - inst 0x12345037 with U → 0x12345000.
  - inst 0x0040006F with J → 0x00000004.
  - imm_type=111 → 0.
  - In each case alu_out equals imm_out.
- Register operand ALU ops, use_imm=0:
  - src0=5, src1=7, SUB → 0xFFFFFFFE.
  - src0=0x80000000, src1=4: SRA → 0xF8000000; SRL → 0x08000000.
  - src1=0x24 with SLL of src0=1 → 0x00000010 (shift amount is 4).
- Compares:
  - src0=0xFFFFFFFF, src1=1: SLT → 1, SLTU → 0.
  - fn=1111 → 0.
- Hold and reset mid-operation:
  - in_valid=0 after a result of 0x1: out_valid=0 and alu_out stays 0x1.
  - Pull rst low between clock edges: outputs clear to 0 immediately, before the next edge.
- Back-to-back: three consecutive valid ADDs (1+1, 2+2, 3+3) → alu_out 2, 4, 6 on three consecutive cycles with out_valid=1.
